// File: rtl/processorci_bus_pkg.sv
// Shared types for the core-to-Wishbone bridge: engine states, port ids,
// and the latched request bundle that each engine holds.
package processorci_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } bridge_state_t;

  typedef enum logic {
    PORT_IF,
    PORT_D
  } port_id_t;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  // Default request shape; wb_core_bridge builds the same layout at its own widths.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]   addr;
    logic                        we;
    logic [DEF_DATA_WIDTH-1:0]   wdata;
    logic [DEF_DATA_WIDTH/8-1:0] sel;
  } bus_req_t;

  function automatic port_id_t other_port(input port_id_t p);
    return (p == PORT_IF) ? PORT_D : PORT_IF;
  endfunction

endpackage

// File: rtl/wb_bridge_channel.sv
// One Wishbone-classic engine: latches a request in IDLE, holds cyc/stb in
// BUSY until ack or watchdog expiry, then spends one RESP cycle pulsing valid.
// The read-data value and strobe are handed to the owner, which keeps the
// per-port rdata registers.
module wb_bridge_channel
  import processorci_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = '0,
  parameter type                   req_t          = bus_req_t
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  input  req_t                    req_data_i,
  output logic                    accept_o,
  output logic                    valid_o,
  output logic                    timeout_o,
  output logic                    capture_o,
  output logic [DATA_WIDTH-1:0]   capture_data_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i
);

  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  bridge_state_t        state_q, state_d;
  req_t                 req_q;
  logic [CNT_WIDTH-1:0] wdog_q;
  logic                 timed_out_q;
  logic                 expire;

  // The counter reads TIMEOUT_CYCLES-1 on the last allowed BUSY cycle.
  assign expire   = (TIMEOUT_CYCLES != 0) && (wdog_q == CNT_LAST);
  assign accept_o = (state_q == IDLE) && req_i;

  // Next-state and completion decode; ack beats a simultaneous expiry.
  always_comb begin
    state_d        = state_q;
    capture_o      = 1'b0;
    capture_data_o = wb_data_i;
    case (state_q)
      IDLE: begin
        if (req_i) state_d = BUSY;
      end
      BUSY: begin
        if (wb_ack_i) begin
          state_d   = RESP;
          capture_o = !req_q.we;
        end else if (expire) begin
          state_d        = RESP;
          capture_o      = !req_q.we;
          capture_data_o = ERR_DATA;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Engine state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request latch, loaded only when a request is accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        req_q <= '0;
    else if (accept_o) req_q <= req_data_i;
  end

  // Watchdog: cleared on BUSY entry, counts BUSY cycles without ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              wdog_q <= '0;
    else if (accept_o)                       wdog_q <= '0;
    else if (state_q == BUSY && !wb_ack_i)   wdog_q <= wdog_q + 1'b1;
  end

  // Remember an abort so the timeout pulse lines up with the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timed_out_q <= 1'b0;
    else        timed_out_q <= (state_q == BUSY) && !wb_ack_i && expire;
  end

  assign wb_cyc_o  = (state_q == BUSY);
  assign wb_stb_o  = (state_q == BUSY);
  assign wb_we_o   = req_q.we;
  assign wb_addr_o = req_q.addr;
  assign wb_data_o = req_q.wdata;
  assign wb_sel_o  = req_q.sel;
  assign valid_o   = (state_q == RESP);
  assign timeout_o = timed_out_q;

endmodule

// File: rtl/wb_core_bridge.sv
// Bridge from the core's request/hold fetch and data ports onto Wishbone.
// Split mode gives each port its own engine and bus; shared mode arbitrates
// both ports onto a single engine driving bus 0 and ties bus 1 off.
module wb_core_bridge
  import processorci_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    SHARED_BUS     = 0,
  parameter int                    ARB_MODE       = 0,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_valid_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_sel_i,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    d_valid_o,
  output logic                    hold_o,
  output logic                    timeout_o,
  output logic                    wb0_cyc_o,
  output logic                    wb0_stb_o,
  output logic                    wb0_we_o,
  output logic [ADDR_WIDTH-1:0]   wb0_addr_o,
  output logic [DATA_WIDTH-1:0]   wb0_data_o,
  output logic [DATA_WIDTH/8-1:0] wb0_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb0_data_i,
  input  logic                    wb0_ack_i,
  output logic                    wb1_cyc_o,
  output logic                    wb1_stb_o,
  output logic                    wb1_we_o,
  output logic [ADDR_WIDTH-1:0]   wb1_addr_o,
  output logic [DATA_WIDTH-1:0]   wb1_data_o,
  output logic [DATA_WIDTH/8-1:0] wb1_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb1_data_i,
  input  logic                    wb1_ack_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SEL_WIDTH-1:0]  sel;
  } req_t;

  req_t                  if_req, d_req;
  logic [DATA_WIDTH-1:0] if_rdata_q, d_rdata_q;

  // Fetches are always full-word reads.
  always_comb begin
    if_req       = '0;
    if_req.addr  = if_addr_i;
    if_req.sel   = '1;
    d_req        = '0;
    d_req.addr   = d_addr_i;
    d_req.we     = d_we_i;
    d_req.wdata  = d_wdata_i;
    d_req.sel    = d_sel_i;
  end

  assign hold_o     = (if_req_i & ~if_valid_o) | (d_req_i & ~d_valid_o);
  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o  = d_rdata_q;

  if (SHARED_BUS == 0) begin : g_split
    logic                  if_accept, d_accept, if_cap, d_cap, if_to, d_to;
    logic [DATA_WIDTH-1:0] if_cap_data, d_cap_data;
    logic                  unused_accept;

    assign unused_accept = if_accept ^ d_accept;
    assign timeout_o     = if_to | d_to;

    wb_bridge_channel #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ERR_DATA(ERR_DATA), .req_t(req_t)
    ) u_if_channel (
      .clk(clk), .rst_n(rst_n), .req_i(if_req_i), .req_data_i(if_req),
      .accept_o(if_accept), .valid_o(if_valid_o), .timeout_o(if_to),
      .capture_o(if_cap), .capture_data_o(if_cap_data),
      .wb_cyc_o(wb0_cyc_o), .wb_stb_o(wb0_stb_o), .wb_we_o(wb0_we_o),
      .wb_addr_o(wb0_addr_o), .wb_data_o(wb0_data_o), .wb_sel_o(wb0_sel_o),
      .wb_data_i(wb0_data_i), .wb_ack_i(wb0_ack_i)
    );

    wb_bridge_channel #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ERR_DATA(ERR_DATA), .req_t(req_t)
    ) u_d_channel (
      .clk(clk), .rst_n(rst_n), .req_i(d_req_i), .req_data_i(d_req),
      .accept_o(d_accept), .valid_o(d_valid_o), .timeout_o(d_to),
      .capture_o(d_cap), .capture_data_o(d_cap_data),
      .wb_cyc_o(wb1_cyc_o), .wb_stb_o(wb1_stb_o), .wb_we_o(wb1_we_o),
      .wb_addr_o(wb1_addr_o), .wb_data_o(wb1_data_o), .wb_sel_o(wb1_sel_o),
      .wb_data_i(wb1_data_i), .wb_ack_i(wb1_ack_i)
    );

    // Per-port read data, updated only on load completion.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        if_rdata_q <= '0;
        d_rdata_q  <= '0;
      end else begin
        if (if_cap) if_rdata_q <= if_cap_data;
        if (d_cap)  d_rdata_q  <= d_cap_data;
      end
    end

  end else begin : g_shared
    port_id_t              grant, owner_q, rr_ptr_q;
    req_t                  granted_req;
    logic                  accept, valid, cap;
    logic [DATA_WIDTH-1:0] cap_data;
    logic                  unused_wb1;

    assign unused_wb1 = ^{wb1_data_i, wb1_ack_i};

    // Pick a port; rr_ptr_q names the port favoured on the next tie.
    always_comb begin
      grant = PORT_IF;
      if (if_req_i && d_req_i) grant = (ARB_MODE == 0) ? PORT_D : rr_ptr_q;
      else if (d_req_i)        grant = PORT_D;
    end

    assign granted_req = (grant == PORT_D) ? d_req : if_req;
    assign if_valid_o  = valid && (owner_q == PORT_IF);
    assign d_valid_o   = valid && (owner_q == PORT_D);

    wb_bridge_channel #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ERR_DATA(ERR_DATA), .req_t(req_t)
    ) u_channel (
      .clk(clk), .rst_n(rst_n), .req_i(if_req_i | d_req_i), .req_data_i(granted_req),
      .accept_o(accept), .valid_o(valid), .timeout_o(timeout_o),
      .capture_o(cap), .capture_data_o(cap_data),
      .wb_cyc_o(wb0_cyc_o), .wb_stb_o(wb0_stb_o), .wb_we_o(wb0_we_o),
      .wb_addr_o(wb0_addr_o), .wb_data_o(wb0_data_o), .wb_sel_o(wb0_sel_o),
      .wb_data_i(wb0_data_i), .wb_ack_i(wb0_ack_i)
    );

    // Owner and round-robin pointer advance only when a grant is taken.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        owner_q  <= PORT_IF;
        rr_ptr_q <= PORT_IF;
      end else if (accept) begin
        owner_q  <= grant;
        rr_ptr_q <= other_port(grant);
      end
    end

    // Route captured load data to the port that owns the transaction.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        if_rdata_q <= '0;
        d_rdata_q  <= '0;
      end else if (cap) begin
        if (owner_q == PORT_IF) if_rdata_q <= cap_data;
        else                    d_rdata_q  <= cap_data;
      end
    end

    assign wb1_cyc_o  = 1'b0;
    assign wb1_stb_o  = 1'b0;
    assign wb1_we_o   = 1'b0;
    assign wb1_addr_o = '0;
    assign wb1_data_o = '0;
    assign wb1_sel_o  = '0;
  end

endmodule

// File: doc/wb_core_bridge.md
Name: wb_core_bridge

Overview:
- Parametrised bridge between a core's simple request/hold memory ports (instruction fetch plus data load/store) and the Controller's Wishbone-classic buses.
- Replaces tie-off glue (constant cyc/stb/ack) with real wait-state handling, a stall (hold) output, a bus-timeout watchdog, and an optional shared-bus mode that arbitrates both ports onto one Wishbone master.
- Sits between the core instance and the Controller in processorci_top.

Parameters:
- ADDR_WIDTH, 32, address width of both ports and buses.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- SHARED_BUS, 0: 0 = fetch on bus 0 and data on bus 1; 1 = both ports arbitrated onto bus 0, bus 1 outputs tied 0.
- ARB_MODE, 0: shared-bus arbitration; 0 = fixed data priority, 1 = round-robin.
- TIMEOUT_CYCLES, 1024: BUSY cycles without ack before abort; 0 disables the watchdog.
- ERR_DATA, 32'h0000_0000: read data returned on timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request; held with address until if_valid_o
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_rdata_o  out  DATA_WIDTH  fetched word, registered
- if_valid_o  out  1  one-cycle fetch completion pulse
- d_req_i  in  1  data request; held until d_valid_o
- d_we_i  in  1  1 = store
- d_addr_i  in  ADDR_WIDTH  data address
- d_wdata_i  in  DATA_WIDTH  store data
- d_sel_i  in  DATA_WIDTH/8  byte enables
- d_rdata_o  out  DATA_WIDTH  load data, registered
- d_valid_o  out  1  one-cycle data completion pulse
- hold_o  out  1  core stall
- timeout_o  out  1  one-cycle pulse on watchdog abort
- wb0_cyc_o, wb0_stb_o, wb0_we_o  out  1 each  bus 0 Wishbone controls
- wb0_addr_o  out  ADDR_WIDTH;  wb0_data_o  out  DATA_WIDTH;  wb0_sel_o  out  DATA_WIDTH/8
- wb0_data_i  in  DATA_WIDTH;  wb0_ack_i  in  1
- wb1_*  same set as wb0_*, data-port bus (SHARED_BUS=0 only)

Behaviour:
- Reset (async, immediate):
  - All Wishbone outputs 0; valid/timeout 0.
  - rdata registers 0.
  - Engines IDLE; round-robin pointer = fetch.
- Engine FSM, one per bus: IDLE -> BUSY -> RESP -> IDLE.
  - IDLE: a request sampled high (after arbitration) latches addr/we/wdata/sel. Next cycle: BUSY, cyc=stb=1.
  - BUSY: outputs stable. On ack_i=1: drop cyc/stb, capture data_i into the port's rdata (loads only; stores leave rdata unchanged), go RESP.
  - RESP: the owning port's valid=1 for exactly one cycle. Requests are ignored this cycle so a still-high req is not re-issued. Then IDLE.
- Latency: req at cycle 0 -> cyc/stb at cycle 1 -> ack at cycle N>=1 -> valid at cycle N+1. Back-to-back throughput is one access per 3 cycles with a zero-wait slave.
- Watchdog:
  - Counter clears on BUSY entry and increments each BUSY cycle without ack.
  - At TIMEOUT_CYCLES it drops cyc/stb, loads ERR_DATA (loads only), pulses timeout_o, and goes RESP.
  - Ack in the same cycle as expiry wins: normal completion, no timeout.
- Ack while not BUSY is ignored.
- hold_o = (if_req_i & ~if_valid_o) | (d_req_i & ~d_valid_o). It is combinational from the request inputs.
- Shared-bus arbitration, in IDLE only:
  - ARB_MODE=0: data wins on a tie.
  - ARB_MODE=1: on a tie, grant the port not granted last. The pointer updates on each grant.
  - A grant holds until RESP completes; the losing port waits, with hold_o staying high.
- Dropping req while BUSY is a protocol violation. The transaction still completes and valid still pulses.

Decomposition:
- Package processorci_bus_pkg holds:
  - bridge_state_t enum {IDLE, BUSY, RESP};
  - port_id_t {PORT_IF, PORT_D};
  - the request struct (addr, we, wdata, sel).
- Sub-module wb_bridge_channel: one engine with FSM, request latch, watchdog, and rdata capture. It is instantiated twice (SHARED_BUS=0), or once behind an arbiter that is local to wb_core_bridge (SHARED_BUS=1).

Test Plan:
- SHARED_BUS=0, fetch 0x100, ack cycle 1 with data 0x00000013 -> wb0 cyc at cycle 1, if_valid at cycle 2 with rdata 0x00000013, hold_o high in cycles 0-1.
- Store 0xCAFEBABE, sel 4'b0011, to 0x2000 with 3 wait states -> wb1 outputs stable for 4 cycles, d_valid one pulse, d_rdata unchanged.
- TIMEOUT_CYCLES=8, no ack on a load -> cyc drops after 8 BUSY cycles, timeout_o and d_valid pulse together, d_rdata=ERR_DATA; ack arriving on the expiry cycle -> no timeout.
- SHARED_BUS=1, ARB_MODE=1, both ports requesting continuously -> grants alternate IF, D, IF, D, starting with IF after reset; only wb0 toggles.
- SHARED_BUS=1, ARB_MODE=0, simultaneous requests -> data served first, fetch valid 3 cycles later with a zero-wait slave.
- rst_n low mid-BUSY -> cyc/stb/valid low asynchronously; after release the first request is issued normally.
